// File: rtl/reg_bank.sv
// Bank of DEPTH registers on a shared tri-state bus with per-register inc/dec/shift/clear and zero/carry flags.
// Register 0 is exported as acc. Define REG_BANK_SHADOW_EN to add a save/restore shadow bank.
module reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             ld,
    input  logic [AW-1:0]    wr_addr,
    input  logic             oe,
    input  logic [AW-1:0]    rd_addr,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    op_addr,
`ifdef REG_BANK_SHADOW_EN
    input  logic             save,
    input  logic             restore,
    output logic             shadow_valid,
`endif
    output logic [WIDTH-1:0] acc,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_INC = 3'd1,
        OP_DEC = 3'd2,
        OP_SHL = 3'd3,
        OP_SHR = 3'd4,
        OP_CLR = 3'd5
    } op_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] op_result;
    logic             op_carry;
    logic             op_valid;
    logic             do_ld;
    logic             do_op;
    logic             do_restore;

    // The bus always carries the pre-edge register value; reset forces release.
    assign bus = (oe && !rst) ? regs[rd_addr] : {WIDTH{1'bz}};
    assign acc = regs[0];

    always_comb begin
        cur       = regs[op_addr];
        op_result = cur;
        op_carry  = 1'b0;
        op_valid  = 1'b1;
        case (op)
            OP_INC: begin
                op_result = cur + ONE;
                op_carry  = (cur == {WIDTH{1'b1}});
            end
            OP_DEC: begin
                op_result = cur - ONE;
                op_carry  = (cur == '0);
            end
            OP_SHL: begin
                op_result = {cur[WIDTH-2:0], 1'b0};
                op_carry  = cur[WIDTH-1];
            end
            OP_SHR: begin
                op_result = {1'b0, cur[WIDTH-1:1]};
                op_carry  = cur[0];
            end
            OP_CLR: begin
                op_result = '0;
                op_carry  = 1'b0;
            end
            default: op_valid = 1'b0;
        endcase
    end

`ifdef REG_BANK_SHADOW_EN
    logic [WIDTH-1:0] shadow_regs [DEPTH];
    logic             shadow_zero;
    logic             shadow_carry;

    assign do_restore = restore && shadow_valid;
`else
    assign do_restore = 1'b0;
`endif

    // A load to the same register as an op wins; a live restore discards both.
    assign do_ld = ld && !do_restore;
    assign do_op = op_valid && !do_restore && !(ld && (wr_addr == op_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            zero  <= 1'b1;
            carry <= 1'b0;
        end else if (do_restore) begin
`ifdef REG_BANK_SHADOW_EN
            for (int i = 0; i < DEPTH; i++) regs[i] <= shadow_regs[i];
            zero  <= shadow_zero;
            carry <= shadow_carry;
`endif
        end else begin
            if (do_op) regs[op_addr] <= op_result;
            if (do_ld) regs[wr_addr] <= bus;
            if (do_op) begin
                zero  <= (op_result == '0);
                carry <= op_carry;
            end else if (do_ld) begin
                zero  <= (bus == '0);
                carry <= 1'b0;
            end
        end
    end

`ifdef REG_BANK_SHADOW_EN
    // Save snapshots pre-edge state; any restore request suppresses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) shadow_regs[i] <= '0;
            shadow_zero  <= 1'b0;
            shadow_carry <= 1'b0;
            shadow_valid <= 1'b0;
        end else if (restore) begin
            if (shadow_valid) shadow_valid <= 1'b0;
        end else if (save) begin
            for (int i = 0; i < DEPTH; i++) shadow_regs[i] <= regs[i];
            shadow_zero  <= zero;
            shadow_carry <= carry;
            shadow_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank; covers the shadow bank when REG_BANK_SHADOW_EN is defined.
module tb_reg_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    wire  [WIDTH-1:0] bus;
    logic             ld = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic             oe = 1'b0;
    logic [AW-1:0]    rd_addr = '0;
    logic [2:0]       op = 3'd0;
    logic [AW-1:0]    op_addr = '0;
    logic [WIDTH-1:0] acc;
    logic             zero;
    logic             carry;
    logic             tb_en = 1'b0;
    logic [WIDTH-1:0] tb_data = '0;
`ifdef REG_BANK_SHADOW_EN
    logic             save = 1'b0;
    logic             restore = 1'b0;
    logic             shadow_valid;
`endif

    int total = 0;
    int bad   = 0;

    assign bus = tb_en ? tb_data : {WIDTH{1'bz}};

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .ld(ld),
        .wr_addr(wr_addr),
        .oe(oe),
        .rd_addr(rd_addr),
        .op(op),
        .op_addr(op_addr),
`ifdef REG_BANK_SHADOW_EN
        .save(save),
        .restore(restore),
        .shadow_valid(shadow_valid),
`endif
        .acc(acc),
        .zero(zero),
        .carry(carry)
    );

    // Inputs change at the falling edge; one tick crosses one rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        tb_en = 1'b1; tb_data = d; ld = 1'b1; wr_addr = a;
        tick();
        tb_en = 1'b0; ld = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [AW-1:0] a);
        op = o; op_addr = a;
        tick();
        op = 3'd0;
    endtask

    task automatic read_reg(input logic [AW-1:0] a, output logic [WIDTH-1:0] v);
        oe = 1'b1; rd_addr = a;
        #1 v = bus;
        oe = 1'b0;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] v;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (acc !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin bad++; $display("[TB] FAIL reset_state acc=%h z=%b c=%b want 00 1 0", acc, zero, carry); end
        load(2'd0, 8'h42);
        total++; if (acc !== 8'h42 || zero !== 1'b0) begin bad++; $display("[TB] FAIL pre_reset_load acc=%h z=%b want 42 0", acc, zero); end
        op = 3'd1; op_addr = 2'd0; oe = 1'b1; rd_addr = 2'd0;
        #2 rst = 1'b1;
        #1;
        total++; if (acc !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin bad++; $display("[TB] FAIL async_reset acc=%h z=%b c=%b want 00 1 0", acc, zero, carry); end
        tick();
        total++; if (acc !== 8'h00) begin bad++; $display("[TB] FAIL reset_aborts_op acc=%h want 00", acc); end
        op = 3'd0; oe = 1'b0; rst = 1'b0;
        tick();
        read_reg(2'd2, v);
        total++; if (v !== 8'h00) begin bad++; $display("[TB] FAIL reset_reg2 bus=%h want 00", v); end
    endtask

    task automatic test_load_readback();
        logic [WIDTH-1:0] v;
        load(2'd1, 8'hA5);
        read_reg(2'd1, v);
        total++; if (v !== 8'hA5 || zero !== 1'b0 || carry !== 1'b0) begin bad++; $display("[TB] FAIL load_readback bus=%h z=%b c=%b want a5 0 0", v, zero, carry); end
        load(2'd2, 8'h00);
        total++; if (zero !== 1'b1 || carry !== 1'b0) begin bad++; $display("[TB] FAIL load_zero_flag z=%b c=%b want 1 0", zero, carry); end
    endtask

    task automatic test_wrap();
        load(2'd0, 8'hFF);
        do_op(3'd1, 2'd0);
        total++; if (acc !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin bad++; $display("[TB] FAIL inc_wrap acc=%h z=%b c=%b want 00 1 1", acc, zero, carry); end
        do_op(3'd2, 2'd0);
        total++; if (acc !== 8'hFF || zero !== 1'b0 || carry !== 1'b1) begin bad++; $display("[TB] FAIL dec_wrap acc=%h z=%b c=%b want ff 0 1", acc, zero, carry); end
        do_op(3'd2, 2'd0);
        total++; if (acc !== 8'hFE || zero !== 1'b0 || carry !== 1'b0) begin bad++; $display("[TB] FAIL dec_plain acc=%h z=%b c=%b want fe 0 0", acc, zero, carry); end
    endtask

    task automatic test_shifts();
        logic [WIDTH-1:0] v;
        load(2'd2, 8'h81);
        do_op(3'd3, 2'd2);
        read_reg(2'd2, v);
        total++; if (v !== 8'h02 || carry !== 1'b1 || zero !== 1'b0) begin bad++; $display("[TB] FAIL shl reg2=%h c=%b z=%b want 02 1 0", v, carry, zero); end
        do_op(3'd4, 2'd2);
        read_reg(2'd2, v);
        total++; if (v !== 8'h01 || carry !== 1'b0 || zero !== 1'b0) begin bad++; $display("[TB] FAIL shr1 reg2=%h c=%b z=%b want 01 0 0", v, carry, zero); end
        do_op(3'd4, 2'd2);
        read_reg(2'd2, v);
        total++; if (v !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin bad++; $display("[TB] FAIL shr2 reg2=%h c=%b z=%b want 00 1 1", v, carry, zero); end
    endtask

    task automatic test_conflict_move();
        logic [WIDTH-1:0] v;
        tb_en = 1'b1; tb_data = 8'h10; ld = 1'b1; wr_addr = 2'd3; op = 3'd1; op_addr = 2'd3;
        tick();
        tb_en = 1'b0; ld = 1'b0; op = 3'd0;
        read_reg(2'd3, v);
        total++; if (v !== 8'h10 || carry !== 1'b0 || zero !== 1'b0) begin bad++; $display("[TB] FAIL ld_wins reg3=%h c=%b z=%b want 10 0 0", v, carry, zero); end
        oe = 1'b1; rd_addr = 2'd3; ld = 1'b1; wr_addr = 2'd0;
        tick();
        oe = 1'b0; ld = 1'b0;
        total++; if (acc !== 8'h10) begin bad++; $display("[TB] FAIL move acc=%h want 10", acc); end
        do_op(3'd6, 2'd0);
        total++; if (acc !== 8'h10 || zero !== 1'b0 || carry !== 1'b0) begin bad++; $display("[TB] FAIL reserved6 acc=%h z=%b c=%b want 10 0 0", acc, zero, carry); end
        load(2'd1, 8'hFF);
        do_op(3'd1, 2'd1);
        do_op(3'd7, 2'd1);
        read_reg(2'd1, v);
        total++; if (v !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin bad++; $display("[TB] FAIL reserved7_hold reg1=%h z=%b c=%b want 00 1 1", v, zero, carry); end
        tb_en = 1'b1; tb_data = 8'h00; ld = 1'b1; wr_addr = 2'd2; op = 3'd1; op_addr = 2'd1;
        tick();
        tb_en = 1'b0; ld = 1'b0; op = 3'd0;
        read_reg(2'd1, v);
        total++; if (v !== 8'h01 || zero !== 1'b0 || carry !== 1'b0) begin bad++; $display("[TB] FAIL split_op reg1=%h z=%b c=%b want 01 0 0", v, zero, carry); end
        read_reg(2'd2, v);
        total++; if (v !== 8'h00) begin bad++; $display("[TB] FAIL split_ld reg2=%h want 00", v); end
        do_op(3'd5, 2'd1);
        read_reg(2'd1, v);
        total++; if (v !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin bad++; $display("[TB] FAIL clr reg1=%h z=%b c=%b want 00 1 0", v, zero, carry); end
    endtask

`ifdef REG_BANK_SHADOW_EN
    task automatic test_shadow();
        total++; if (shadow_valid !== 1'b0) begin bad++; $display("[TB] FAIL shadow_reset sv=%b want 0", shadow_valid); end
        load(2'd0, 8'h33);
        save = 1'b1; tick(); save = 1'b0;
        total++; if (shadow_valid !== 1'b1) begin bad++; $display("[TB] FAIL save_valid sv=%b want 1", shadow_valid); end
        do_op(3'd5, 2'd0);
        total++; if (acc !== 8'h00 || zero !== 1'b1) begin bad++; $display("[TB] FAIL clr_acc acc=%h z=%b want 00 1", acc, zero); end
        restore = 1'b1; op = 3'd1; op_addr = 2'd0;
        tick();
        restore = 1'b0; op = 3'd0;
        total++; if (acc !== 8'h33 || shadow_valid !== 1'b0 || zero !== 1'b0) begin bad++; $display("[TB] FAIL restore acc=%h sv=%b z=%b want 33 0 0", acc, shadow_valid, zero); end
        restore = 1'b1; tick(); restore = 1'b0;
        total++; if (acc !== 8'h33) begin bad++; $display("[TB] FAIL restore_ignored acc=%h want 33", acc); end
        do_op(3'd1, 2'd0);
        total++; if (acc !== 8'h34) begin bad++; $display("[TB] FAIL inc_after acc=%h want 34", acc); end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_load_readback();
        test_wrap();
        test_shifts();
        test_conflict_move();
`ifdef REG_BANK_SHADOW_EN
        test_shadow();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
